// File: rtl/step_pio_pkg.sv
// step_pio_pkg: register map, STATUS bit positions and pulse FSM states
// shared by the step pulse PIO top and its pulse generator.
package step_pio_pkg;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_PERIOD = 3'd1;
  localparam logic [2:0] ADDR_COUNT  = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

endpackage

// File: rtl/step_pio_pulse_if.sv
// step_pio_pulse_if: Avalon-MM slave bus of the step pulse PIO,
// zero wait states, readdata combinational from address.
interface step_pio_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/step_pulse_gen.sv
// step_pulse_gen: IDLE/HIGH/LOW burst FSM with phase counter,
// remaining-pulse counter and sticky done flag.
module step_pulse_gen
  import step_pio_pkg::*;
#(
  parameter int PERIOD_W = 16,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_cnt_wr,
  input  logic [CNT_W-1:0]    i_cnt_val,
  input  logic                i_abort,
  input  logic                i_clr_done,
  output logic                o_pulse,
  output logic                o_busy,
  output logic [CNT_W-1:0]    o_remain,
  output logic                o_done
);

  state_t              r_state, w_state_nx;
  logic [PERIOD_W-1:0] r_phase, w_phase_nx;
  logic [CNT_W-1:0]    r_remain, w_remain_nx;
  logic                r_pulse, w_pulse_nx;
  logic                r_done, w_done_nx;
  logic [PERIOD_W-1:0] w_load;

  // phase counts down to 0, so a period of 0 behaves as 1
  assign w_load = (i_period == '0) ? '0
                : i_period - PERIOD_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_phase  <= '0;
      r_remain <= '0;
      r_pulse  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_phase  <= w_phase_nx;
      r_remain <= w_remain_nx;
      r_pulse  <= w_pulse_nx;
      r_done   <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_phase_nx  = r_phase;
    w_remain_nx = r_remain;
    w_pulse_nx  = r_pulse;
    w_done_nx   = r_done & ~i_clr_done;
    case (r_state)
      IDLE: begin
        if (i_cnt_wr && i_cnt_val != '0) begin
          w_state_nx  = HIGH;
          w_remain_nx = i_cnt_val;
          w_pulse_nx  = 1'b1;
          w_phase_nx  = w_load;
        end
      end
      HIGH: begin
        if (r_phase == '0) begin
          w_state_nx = LOW;
          w_pulse_nx = 1'b0;
          w_phase_nx = w_load;
        end else begin
          w_phase_nx = r_phase - PERIOD_W'(1);
        end
      end
      LOW: begin
        if (r_phase == '0) begin
          w_remain_nx = r_remain - CNT_W'(1);
          if (r_remain == CNT_W'(1)) begin
            w_state_nx = IDLE;
            w_done_nx  = 1'b1;
          end else begin
            w_state_nx = HIGH;
            w_pulse_nx = 1'b1;
            w_phase_nx = w_load;
          end
        end else begin
          w_phase_nx = r_phase - PERIOD_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase
    // abort kills the burst without reporting completion
    if (i_abort) begin
      w_state_nx  = IDLE;
      w_phase_nx  = '0;
      w_remain_nx = '0;
      w_pulse_nx  = 1'b0;
      w_done_nx   = r_done & ~i_clr_done;
    end
  end

  assign o_pulse  = r_pulse;
  assign o_busy   = (r_state != IDLE);
  assign o_remain = r_remain;
  assign o_done   = r_done;

endmodule

// File: rtl/step_pio_pulse.sv
// step_pio_pulse: Avalon-MM output PIO plus hardware step-pulse burst.
// Define STEP_PIO_IRQ_EN to drive irq from the done flag.
module step_pio_pulse
  import step_pio_pkg::*;
#(
  parameter int          WIDTH     = 8,
  parameter int          PERIOD_W  = 16,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] RESET_VAL = 32'd0
) (
  input  logic             clk,
  input  logic             reset_n,
  step_pio_pulse_if.slave  bus,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_out,
  output logic             busy,
  output logic             irq
);

  logic [WIDTH-1:0]    r_data;
  logic [PERIOD_W-1:0] r_period;
  logic                w_wr;
  logic                w_wr_data, w_wr_per, w_wr_cnt;
  logic                w_wr_stat, w_wr_set, w_wr_clr;
  logic [CNT_W-1:0]    w_remain;
  logic                w_done;
  logic [WIDTH-1:0]    w_wd;

  assign w_wr      = bus.chipselect & ~bus.write_n;
  assign w_wr_data = w_wr && bus.address == ADDR_DATA;
  assign w_wr_per  = w_wr && bus.address == ADDR_PERIOD;
  assign w_wr_cnt  = w_wr && bus.address == ADDR_COUNT;
  assign w_wr_stat = w_wr && bus.address == ADDR_STATUS;
  assign w_wr_set  = w_wr && bus.address == ADDR_OUTSET;
  assign w_wr_clr  = w_wr && bus.address == ADDR_OUTCLR;
  assign w_wd      = bus.writedata[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= RESET_VAL[WIDTH-1:0];
      r_period <= PERIOD_W'(1);
    end else begin
      if (w_wr_data)
        r_data <= w_wd;
      else if (w_wr_set)
        r_data <= r_data | w_wd;
      else if (w_wr_clr)
        r_data <= r_data & ~w_wd;
      if (w_wr_per)
        r_period <= bus.writedata[PERIOD_W-1:0];
    end
  end

  step_pulse_gen #(
    .PERIOD_W (PERIOD_W),
    .CNT_W    (CNT_W)
  ) u_gen (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_period   (r_period),
    .i_cnt_wr   (w_wr_cnt),
    .i_cnt_val  (bus.writedata[CNT_W-1:0]),
    .i_abort    (w_wr_stat & bus.writedata[STAT_BUSY]),
    .i_clr_done (w_wr_stat & bus.writedata[STAT_DONE]),
    .o_pulse    (pulse_out),
    .o_busy     (busy),
    .o_remain   (w_remain),
    .o_done     (w_done)
  );

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      ADDR_DATA:   bus.readdata = 32'(r_data);
      ADDR_PERIOD: bus.readdata = 32'(r_period);
      ADDR_COUNT:  bus.readdata = 32'(w_remain);
      ADDR_STATUS: bus.readdata = {30'd0, w_done, busy};
      default:     bus.readdata = '0;
    endcase
  end

  assign out_port = r_data;

`ifdef STEP_PIO_IRQ_EN
  assign irq = w_done;
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_step_pio_pulse.sv
// tb_step_pio_pulse: register-map vector table plus directed
// burst, abort, reset and irq sequences for step_pio_pulse.
module tb_step_pio_pulse;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] out_port;
  logic       pulse_out, busy, irq;
  int         n_cmp = 0;
  int         n_bad = 0;

`ifdef STEP_PIO_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  step_pio_pulse_if bus();

  step_pio_pulse #(
    .WIDTH     (8),
    .PERIOD_W  (16),
    .CNT_W     (16),
    .RESET_VAL (32'd0)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .out_port  (out_port),
    .pulse_out (pulse_out),
    .busy      (busy),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [2:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input string nm, input logic [2:0] a,
                    input logic [31:0] exp);
    bus.address = a;
    #1;
    chk(nm, bus.readdata, exp);
  endtask

  task automatic burst(input string nm, input int p, input int n);
    for (int k = 0; k < 2 * p * n; k++) begin
      chk({nm, "_pulse"}, 32'(pulse_out),
          32'((k % (2 * p)) < p));
      chk({nm, "_busy"}, 32'(busy), 32'd1);
      @(posedge clk);
      #1;
    end
    chk({nm, "_end_busy"}, 32'(busy), 32'd0);
    chk({nm, "_end_pulse"}, 32'(pulse_out), 32'd0);
  endtask

  initial begin
    bus.address    = '0;
    bus.writedata  = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;

    tbl[0]  = '{1'b0, 3'd0, 32'h0,       32'h0};
    tbl[1]  = '{1'b0, 3'd1, 32'h0,       32'h1};
    tbl[2]  = '{1'b0, 3'd2, 32'h0,       32'h0};
    tbl[3]  = '{1'b0, 3'd3, 32'h0,       32'h0};
    tbl[4]  = '{1'b0, 3'd6, 32'h0,       32'h0};
    tbl[5]  = '{1'b1, 3'd0, 32'h0F,      32'h0F};
    tbl[6]  = '{1'b1, 3'd4, 32'hF0,      32'hFF};
    tbl[7]  = '{1'b1, 3'd5, 32'h03,      32'hFC};
    tbl[8]  = '{1'b0, 3'd0, 32'h0,       32'hFC};
    tbl[9]  = '{1'b1, 3'd1, 32'h12345,   32'hFC};
    tbl[10] = '{1'b0, 3'd1, 32'h0,       32'h2345};
    tbl[11] = '{1'b1, 3'd7, 32'hFF,      32'hFC};
    tbl[12] = '{1'b1, 3'd0, 32'h1AB,     32'hAB};
    tbl[13] = '{1'b0, 3'd7, 32'h0,       32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_out_port", 32'(out_port), 32'h0);
    chk("rst_pulse", 32'(pulse_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].a, tbl[i].d);
        chk($sformatf("vec%0d_out", i), 32'(out_port),
            tbl[i].exp);
      end else begin
        rd($sformatf("vec%0d_rd", i), tbl[i].a, tbl[i].exp);
      end
    end

    wr(3'd1, 32'd3);
    wr(3'd2, 32'd4);
    burst("p3c4", 3, 4);
    rd("p3c4_remain", 3'd2, 32'd0);
    rd("p3c4_status", 3'd3, 32'd2);
    chk("p3c4_irq", 32'(irq), 32'(IRQ_EN));
    wr(3'd3, 32'd2);
    rd("clr_done_status", 3'd3, 32'd0);
    chk("clr_done_irq", 32'(irq), 32'd0);

    wr(3'd1, 32'd0);
    wr(3'd2, 32'd2);
    burst("p0c2", 1, 2);
    wr(3'd3, 32'd2);

    wr(3'd2, 32'd0);
    chk("cnt0_busy", 32'(busy), 32'd0);
    chk("cnt0_pulse", 32'(pulse_out), 32'd0);
    rd("cnt0_status", 3'd3, 32'd0);

    wr(3'd1, 32'd5);
    wr(3'd2, 32'd10);
    wr(3'd2, 32'd3);
    rd("busy_cnt_ignored", 3'd2, 32'd10);
    repeat (18) @(posedge clk);
    #1;
    chk("pre_abort_pulse", 32'(pulse_out), 32'd0);
    rd("pre_abort_remain", 3'd2, 32'd9);
    wr(3'd3, 32'd1);
    chk("abort_pulse", 32'(pulse_out), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rd("abort_remain", 3'd2, 32'd0);
    rd("abort_status", 3'd3, 32'd0);

    wr(3'd1, 32'd1);
    wr(3'd2, 32'd1);
    burst("p1c1", 1, 1);
    chk("irq_set", 32'(irq), 32'(IRQ_EN));
    wr(3'd3, 32'd2);
    chk("irq_clr", 32'(irq), 32'd0);

    wr(3'd1, 32'd4);
    wr(3'd2, 32'd5);
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_pulse", 32'(pulse_out), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_out_port", 32'(out_port), 32'd0);
    rd("arst_period", 3'd1, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
